// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-PC fetch stage feeding decode.
//   Issues word fetches over a valid/ready request channel, accepts in-order
//   responses of any latency, buffers them in a DEPTH-entry in-order queue and
//   presents {instr, pc, pc+4} to decode with valid/ready. A redirect flushes
//   the queue, and responses still in flight are counted and discarded.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   imem_req_valid/ready/addr         fetch request channel (addr word aligned)
//   imem_rsp_valid/data               in-order response, >= 1 cycle after accept
//   redirect_valid/pc                 taken branch/jump: flush and refetch
//   id_valid/ready, id_instr/pc/pcplus4   registered decode-side outputs
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    // Entry state is implied by three pointers: [head, fill) are FILLED,
    // [fill, tail) are PENDING, everything else is FREE. The extra pointer
    // bit distinguishes a full queue from an empty one.
    logic [PTR_W-1:0] head_q, head_n;
    logic [PTR_W-1:0] fill_q, fill_n;
    logic [PTR_W-1:0] tail_q, tail_n;
    logic [PTR_W-1:0] drop_q, drop_n;
    logic [PTR_W-1:0] pend_cnt;
    logic [PTR_W-1:0] alloc_cnt_n;
    logic [31:0]      pc_q, pc_n;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic             can_req_q, can_req_n;
    logic             req_fire, pop, rsp_fill, rsp_drop;
    logic [IDX_W-1:0] hidx_n;
    logic             id_valid_n;
    logic [31:0]      id_instr_n, id_pc_n;

    // Credit is registered; only the redirect gate is combinational so that
    // no request can issue in the redirect cycle.
    assign imem_req_valid = can_req_q && !redirect_valid;
    assign imem_req_addr  = pc_q;

    // Next-state: pointers, drop counter, pc, credit and next head entry.
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        pop      = id_valid && id_ready;
        pend_cnt = tail_q - fill_q;
        // Anything arriving during a redirect, or while stale responses are
        // still owed, is discarded.
        rsp_drop = imem_rsp_valid && (redirect_valid || (drop_q != '0));
        rsp_fill = imem_rsp_valid && !rsp_drop;

        pc_n   = pc_q;
        head_n = head_q + PTR_W'(pop);
        fill_n = fill_q + PTR_W'(rsp_fill);
        tail_n = tail_q + PTR_W'(req_fire);
        drop_n = drop_q - PTR_W'(rsp_drop);

        if (redirect_valid) begin
            pc_n   = redirect_pc & ~32'h3;
            head_n = tail_q;
            fill_n = tail_q;
            tail_n = tail_q;
            drop_n = drop_q + pend_cnt - PTR_W'(imem_rsp_valid);
        end else if (req_fire) begin
            pc_n = pc_q + 32'd4;
        end

        alloc_cnt_n = tail_n - head_n;
        can_req_n   = (SUM_W'(alloc_cnt_n) + SUM_W'(drop_n)) < SUM_W'(DEPTH);

        // Bypass the word being written this cycle if it lands on the new head.
        hidx_n     = head_n[IDX_W-1:0];
        id_valid_n = (head_n != fill_n);
        id_instr_n = (rsp_fill && (fill_q[IDX_W-1:0] == hidx_n)) ? imem_rsp_data
                                                                 : instr_mem[hidx_n];
        id_pc_n    = pc_mem[hidx_n];
    end

    // State and registered decode outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            drop_q     <= '0;
            pc_q       <= RESET_PC & ~32'h3;
            can_req_q  <= 1'b0;
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= '0;
            id_pcplus4 <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            head_q    <= head_n;
            fill_q    <= fill_n;
            tail_q    <= tail_n;
            drop_q    <= drop_n;
            pc_q      <= pc_n;
            can_req_q <= can_req_n;
            if (req_fire) begin
                pc_mem[tail_q[IDX_W-1:0]] <= pc_q;
            end
            if (rsp_fill) begin
                instr_mem[fill_q[IDX_W-1:0]] <= imem_rsp_data;
            end
            id_valid <= id_valid_n;
            if (id_valid_n) begin
                id_instr   <= id_instr_n;
                id_pc      <= id_pc_n;
                id_pcplus4 <= id_pc_n + 32'd4;
            end
        end
    end

    // A response with nothing pending and nothing owed has no home.
    illegal_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && (drop_q == '0) && (pend_cnt == '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: self-checking bench for instr_fetch_queue.
//   An in-order memory model with programmable latency answers requests; each
//   accepted request pushes the expected {pc, word} onto a scoreboard queue,
//   which is popped and compared on every decode handshake.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;

    instr_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          lat     = 1;
    mreq_t       memq[$];
    exp_t        expq[$];
    logic [31:0] model_pc;
    logic        prev_redir;

    // Per-phase observations used by the directed checks.
    int          first_fire_cyc;
    int          first_idv_cyc;
    int          phase_pops;
    int          phase_fires;
    logic        got_ff;
    logic        got_fp;
    logic [31:0] first_fire_addr;
    logic [31:0] first_pop_pc;
    logic        last_pop;
    logic        last_rsp;
    logic        last_fire;
    logic [31:0] held_instr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_phase();
        first_fire_cyc = -1;
        first_idv_cyc  = -1;
        phase_pops     = 0;
        phase_fires    = 0;
        got_ff         = 1'b0;
        got_fp         = 1'b0;
    endtask

    // One clock: drive inputs after the edge, sample once settled, score.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic fire;
        logic pop;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        pop  = id_valid && id_ready;
        if (prev_redir) check_eq("idv_after_redir", 32'(id_valid), 32'd0);
        if (redir) check_eq("req_in_redir", 32'(imem_req_valid), 32'd0);
        if (pop) begin
            if (expq.size() == 0) begin
                check_eq("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check_eq("id_pc", id_pc, e.pc);
                check_eq("id_instr", id_instr, e.instr);
                check_eq("id_pcplus4", id_pcplus4, e.pc + 32'd4);
            end
            phase_pops++;
            if (!got_fp) begin
                got_fp       = 1'b1;
                first_pop_pc = id_pc;
            end
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        if (fire) begin
            check_eq("req_addr", imem_req_addr, model_pc);
            expq.push_back('{pc: model_pc, instr: memword(model_pc)});
            memq.push_back('{addr: imem_req_addr, due: cyc + lat});
            model_pc = model_pc + 32'd4;
            phase_fires++;
            if (!got_ff) begin
                got_ff          = 1'b1;
                first_fire_addr = imem_req_addr;
                first_fire_cyc  = cyc;
            end
        end
        if (id_valid && first_idv_cyc < 0) first_idv_cyc = cyc;
        if (redir) begin
            expq.delete();
            model_pc = rpc & ~32'h3;
        end
        prev_redir = redir;
        last_pop   = pop;
        last_rsp   = imem_rsp_valid;
        last_fire  = fire;
    endtask

    // Assert reset away from any clock edge, check immediate effect, release.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_id_instr", id_instr, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        memq.delete();
        expq.delete();
        model_pc   = RESET_PC;
        prev_redir = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        model_pc       = RESET_PC;
        prev_redir     = 1'b0;
        held_instr     = '0;
        reset_phase();
        #2;
        reset_n = 1'b0;
        #2;
        check_eq("init_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("init_id_valid", 32'(id_valid), 32'd0);
        check_eq("init_id_instr", id_instr, 32'd0);
        check_eq("init_id_pc", id_pc, 32'd0);
        check_eq("init_id_pcplus4", id_pcplus4, 32'd0);
        check_eq("init_req_addr", imem_req_addr, RESET_PC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming from reset with 1-cycle memory and ready decode.
        lat = 1;
        reset_phase();
        repeat (4) step(1'b1, 1'b0, 32'd0);
        check_eq("first_idv_latency", 32'(first_idv_cyc - first_fire_cyc), 32'd2);
        reset_phase();
        repeat (8) step(1'b1, 1'b0, 32'd0);
        check_eq("throughput_pops", 32'(phase_pops), 32'd8);

        // Mid-stream async reset, then stall decode: exactly DEPTH fetches.
        do_reset();
        reset_phase();
        repeat (6) step(1'b0, 1'b0, 32'd0);
        held_instr = id_instr;
        repeat (4) step(1'b0, 1'b0, 32'd0);
        check_eq("stall_fires", 32'(phase_fires), 32'(DEPTH));
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("stall_id_valid", 32'(id_valid), 32'd1);
        check_eq("stall_instr_hold", id_instr, held_instr);
        check_eq("stall_instr_val", id_instr, memword(RESET_PC));
        reset_phase();
        repeat (12) step(1'b1, 1'b0, 32'd0);
        check_eq("drain_resume_addr", first_fire_addr, 32'h10);
        check_eq("drain_first_pc", first_pop_pc, RESET_PC);
        check_eq("drain_pops_ok", 32'(phase_pops >= 8), 32'd1);

        // 3-cycle memory: two outstanding (0x20, 0x24) then redirect to 0x101.
        lat = 3;
        step(1'b1, 1'b1, 32'h20);
        step(1'b1, 1'b0, 32'd0);
        check_eq("lat3_fire_20", 32'(last_fire), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        check_eq("lat3_fire_24", 32'(last_fire), 32'd1);
        reset_phase();
        step(1'b1, 1'b1, 32'h101);
        repeat (14) step(1'b1, 1'b0, 32'd0);
        check_eq("lat3_next_addr", first_fire_addr, 32'h100);
        check_eq("lat3_first_pc", first_pop_pc, 32'h100);
        check_eq("lat3_pops_ok", 32'(phase_pops >= 3), 32'd1);

        // Redirect colliding with a response and a decode handshake.
        lat = 1;
        repeat (8) step(1'b1, 1'b0, 32'd0);
        reset_phase();
        step(1'b1, 1'b1, 32'h200);
        check_eq("coll_pop", 32'(last_pop), 32'd1);
        check_eq("coll_rsp", 32'(last_rsp), 32'd1);
        check_eq("coll_no_fire", 32'(last_fire), 32'd0);
        reset_phase();
        repeat (8) step(1'b1, 1'b0, 32'd0);
        check_eq("coll_first_pc", first_pop_pc, 32'h200);

        // PC wrap through the top of the address space.
        reset_phase();
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        reset_phase();
        repeat (10) step(1'b1, 1'b0, 32'd0);
        check_eq("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
        check_eq("wrap_pops_ok", 32'(phase_pops >= 4), 32'd1);

        // Reset again mid-stream; fetch restarts at RESET_PC.
        do_reset();
        reset_phase();
        repeat (6) step(1'b1, 1'b0, 32'd0);
        check_eq("rst2_first_addr", first_fire_addr, RESET_PC);
        check_eq("rst2_first_pc", first_pop_pc, RESET_PC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
